acorn_crypt_engine: RTL

- Parametrised ACORN-128 message-phase engine that follows the associated-data phase.
- Processes a runtime-length message, LSB first, one bit per clock.
- Supports encrypt and decrypt modes, applies the 256-step padding/separation tail, and returns the output bits plus the final 293-bit state for tag finalisation.
- Uses a start/busy/done handshake so the top-level controller can sequence init → AD → message → finalize.

---
 rtl/acorn_pkg.sv | 29 ++
 rtl/acorn_crypt_engine_step.sv | 30 +++
 rtl/acorn_crypt_engine.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/acorn_pkg.sv
// Shared constants, FSM encoding and boolean helpers for the ACORN-128 message engine.
package acorn_pkg;

  localparam int STATE_W    = 293;
  localparam int PAD1_STEPS = 128;
  localparam int PAD0_STEPS = 128;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MSG  = 3'd1,
    ST_PAD1 = 3'd2,
    ST_PAD0 = 3'd3,
    ST_DONE = 3'd4
  } fsm_e;

  // Six LFSR segments, updated in this order: dst ^= a ^ b
  localparam int LFSR_DST [0:5] = '{289, 230, 193, 154, 107, 61};
  localparam int LFSR_A   [0:5] = '{235, 196, 160, 111, 66, 23};
  localparam int LFSR_B   [0:5] = '{230, 193, 154, 107, 61, 0};

  function automatic logic maj(input logic x, input logic y, input logic z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  function automatic logic ch(input logic x, input logic y, input logic z);
    return (x & y) ^ (~x & z);
  endfunction

endpackage

// File: rtl/acorn_crypt_engine_step.sv
// One combinational ACORN-128 StateUpdate128: LFSR update, keystream bit, NFSR feedback and shift.
module acorn_step
  import acorn_pkg::*;
(
  input  logic [STATE_W-1:0] state_i,
  input  logic               m_i,
  input  logic               ca_i,
  input  logic               cb_i,
  output logic               ks_o,
  output logic [STATE_W-1:0] next_state_o
);

  logic [STATE_W-1:0] s;
  logic               f;

  // Keystream is taken after the LFSR update; split from the feedback so m may depend on ks
  always_comb begin
    s = state_i;
    for (int k = 0; k < 6; k++) begin
      s[LFSR_DST[k]] = s[LFSR_DST[k]] ^ s[LFSR_A[k]] ^ s[LFSR_B[k]];
    end
    ks_o = s[12] ^ s[154] ^ maj(s[235], s[61], s[193]) ^ ch(s[230], s[111], s[66]);
  end

  always_comb begin
    f = s[0] ^ ~s[107] ^ maj(s[244], s[23], s[160]) ^ (ca_i & s[196]) ^ (cb_i & ks_o);
    next_state_o = {f ^ m_i, s[STATE_W-1:1]};
  end

endmodule

// File: rtl/acorn_crypt_engine.sv
// ACORN-128 message-phase engine: one bit per clock, encrypt/decrypt, 256-step padding tail.
module acorn_crypt_engine
  import acorn_pkg::*;
#(
  parameter int MSG_MAX_BITS = 128,
  parameter int LEN_W        = $clog2(MSG_MAX_BITS + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    mode_in,
  input  logic [LEN_W-1:0]        msg_len_in,
  input  logic [STATE_W-1:0]      state_in,
  input  logic [MSG_MAX_BITS-1:0] data_in,
  output logic                    busy,
  output logic                    done,
  output logic [MSG_MAX_BITS-1:0] data_out,
  output logic [STATE_W-1:0]      state_out
);

  localparam int CNT_W = $clog2(MSG_MAX_BITS + PAD1_STEPS + PAD0_STEPS + 1);
  localparam int IDX_W = (MSG_MAX_BITS > 1) ? $clog2(MSG_MAX_BITS) : 1;

  fsm_e                    fsm_q, fsm_d;
  logic [STATE_W-1:0]      state_q, state_d;
  logic [MSG_MAX_BITS-1:0] data_q, data_d;
  logic [MSG_MAX_BITS-1:0] data_out_q, data_out_d;
  logic                    mode_q, mode_d;
  logic [LEN_W-1:0]        len_q, len_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;

  logic [LEN_W-1:0]   len_sat;
  logic [IDX_W-1:0]   idx;
  logic               last_msg, last_pad1, last_pad0;
  logic               ks, m, ca, msg_bit;
  logic [STATE_W-1:0] step_state;

  assign len_sat   = (msg_len_in > LEN_W'(MSG_MAX_BITS)) ? LEN_W'(MSG_MAX_BITS) : msg_len_in;
  assign idx       = cnt_q[IDX_W-1:0];
  assign msg_bit   = data_q[idx];
  assign last_msg  = (cnt_q == CNT_W'(len_q) - CNT_W'(1));
  assign last_pad1 = (cnt_q == CNT_W'(PAD1_STEPS - 1));
  assign last_pad0 = (cnt_q == CNT_W'(PAD0_STEPS - 1));

  acorn_step u_step (
    .state_i      (state_q),
    .m_i          (m),
    .ca_i         (ca),
    .cb_i         (1'b0),
    .ks_o         (ks),
    .next_state_o (step_state)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q      <= ST_IDLE;
      state_q    <= '0;
      data_q     <= '0;
      data_out_q <= '0;
      mode_q     <= 1'b0;
      len_q      <= '0;
      cnt_q      <= '0;
    end else begin
      fsm_q      <= fsm_d;
      state_q    <= state_d;
      data_q     <= data_d;
      data_out_q <= data_out_d;
      mode_q     <= mode_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
    end
  end

  always_comb begin
    fsm_d = fsm_q;
    unique case (fsm_q)
      ST_IDLE: if (start) fsm_d = (len_sat == '0) ? ST_PAD1 : ST_MSG;
      ST_MSG:  if (last_msg) fsm_d = ST_PAD1;
      ST_PAD1: if (last_pad1) fsm_d = ST_PAD0;
      ST_PAD0: if (last_pad0) fsm_d = ST_DONE;
      ST_DONE: fsm_d = ST_IDLE;
      default: fsm_d = ST_IDLE;
    endcase
  end

  // Decrypt feeds the recovered plaintext back into the state, same as encrypt
  always_comb begin
    m  = 1'b0;
    ca = 1'b0;
    unique case (fsm_q)
      ST_MSG: begin
        m  = mode_q ? (msg_bit ^ ks) : msg_bit;
        ca = 1'b1;
      end
      ST_PAD1: begin
        m  = (cnt_q == '0);
        ca = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    data_out_d = data_out_q;
    mode_d     = mode_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    unique case (fsm_q)
      ST_IDLE: if (start) begin
        state_d    = state_in;
        data_d     = data_in;
        mode_d     = mode_in;
        len_d      = len_sat;
        data_out_d = '0;
        cnt_d      = '0;
      end
      ST_MSG: begin
        state_d         = step_state;
        data_out_d[idx] = msg_bit ^ ks;
        cnt_d           = last_msg ? '0 : cnt_q + CNT_W'(1);
      end
      ST_PAD1: begin
        state_d = step_state;
        cnt_d   = last_pad1 ? '0 : cnt_q + CNT_W'(1);
      end
      ST_PAD0: begin
        state_d = step_state;
        cnt_d   = last_pad0 ? '0 : cnt_q + CNT_W'(1);
      end
      default: cnt_d = '0;
    endcase
  end

  always_comb begin
    busy      = (fsm_q == ST_MSG) || (fsm_q == ST_PAD1) || (fsm_q == ST_PAD0);
    done      = (fsm_q == ST_DONE);
    data_out  = data_out_q;
    state_out = state_q;
  end

endmodule
